hysteresis_counter_table: RTL



---
 rtl/hysteresis_counter_table.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/hysteresis_counter_table.sv
// -----------------------------------------------------------------------------
// hysteresis_counter_table
//
// A table of DEPTH independent hysteresis saturating counters. All entries share
// one update datapath. The table has a registered lookup port and a sequenced
// flush engine that rewrites every entry to RESET_VALUE, one entry per cycle.
//
// Counter rule: an increment from HALF_LOW jumps to HALF_HIGH+COERCIVITY, and a
// decrement from HALF_HIGH jumps to HALF_LOW-COERCIVITY. Every other step moves
// by one. A counter saturates at 0 and at RANGE-1.
//
// Ports:
//   clock            sole clock, rising edge
//   resetn           asynchronous active-low reset
//   lookup_enable    sample lookup_index this cycle
//   lookup_index     entry to read
//   lookup_valid     lookup_count/lookup_taken valid (1 cycle after enable)
//   lookup_count     registered entry value (holds while no lookup)
//   lookup_taken     lookup_count >= HALF_HIGH
//   update_valid     update request
//   update_ready     update can be accepted (low while flushing)
//   update_index     entry to train
//   update_increment increment the entry
//   update_decrement decrement the entry
//   flush_request    start a table flush (sampled in IDLE only)
//   flush_busy       flush in progress
//   flush_done       one-cycle pulse in the first IDLE cycle after a flush
// -----------------------------------------------------------------------------
module hysteresis_counter_table #(
  parameter int DEPTH       = 16,
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 0,
  parameter int COERCIVITY  = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         lookup_enable,
  input  logic [$clog2(DEPTH)-1:0]     lookup_index,
  output logic                         lookup_valid,
  output logic [$clog2(RANGE)-1:0]     lookup_count,
  output logic                         lookup_taken,
  input  logic                         update_valid,
  output logic                         update_ready,
  input  logic [$clog2(DEPTH)-1:0]     update_index,
  input  logic                         update_increment,
  input  logic                         update_decrement,
  input  logic                         flush_request,
  output logic                         flush_busy,
  output logic                         flush_done
);

  localparam int WIDTH       = $clog2(RANGE);
  localparam int INDEX_WIDTH = $clog2(DEPTH);
  localparam int HALF_LOW    = RANGE / 2 - 1;
  localparam int HALF_HIGH   = RANGE / 2;

  localparam logic [WIDTH-1:0]       RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]       MAX_COUNT   = WIDTH'(RANGE - 1);
  localparam logic [WIDTH-1:0]       LOW_COUNT   = WIDTH'(HALF_LOW);
  localparam logic [WIDTH-1:0]       HIGH_COUNT  = WIDTH'(HALF_HIGH);
  localparam logic [WIDTH-1:0]       JUMP_UP     = WIDTH'(HALF_HIGH + COERCIVITY);
  localparam logic [WIDTH-1:0]       JUMP_DOWN   = WIDTH'(HALF_LOW - COERCIVITY);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(DEPTH - 1);

  // Elaboration-time parameter check.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (RANGE < 4) || ((RANGE % 2) != 0) ||
      (RESET_VALUE < 0) || (RESET_VALUE >= RANGE) ||
      (COERCIVITY < 0) || (COERCIVITY > HALF_LOW)) begin : g_bad_params
    $error("hysteresis_counter_table: invalid parameter set");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [INDEX_WIDTH-1:0] flush_ptr_reg, flush_ptr_next;
  logic                   flush_done_reg, flush_done_next;

  logic [WIDTH-1:0]       entry_reg [DEPTH];
  logic [DEPTH-1:0]       entry_we;
  logic [WIDTH-1:0]       entry_wdata;

  logic [WIDTH-1:0]       update_current;
  logic [WIDTH-1:0]       update_value_next;
  logic                   update_fire;
  logic                   flush_write;

  logic                   lookup_valid_reg;
  logic [WIDTH-1:0]       lookup_count_reg;

  // ---------------------------------------------------------------------------
  // Flush sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      flush_ptr_reg  <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_ptr_reg  <= flush_ptr_next;
      flush_done_reg <= flush_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    flush_ptr_next  = flush_ptr_reg;
    flush_done_next = 1'b0;
    flush_write     = 1'b0;
    update_ready    = 1'b0;
    flush_busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        update_ready = 1'b1;
        if (flush_request) begin
          state_next     = FLUSH;
          flush_ptr_next = '0;
        end
      end
      FLUSH: begin
        // flush_request is deliberately ignored here: no restart, no queueing.
        flush_busy     = 1'b1;
        flush_write    = 1'b1;
        flush_ptr_next = flush_ptr_reg + 1'b1;
        if (flush_ptr_reg == LAST_INDEX) begin
          state_next      = IDLE;
          flush_ptr_next  = '0;
          flush_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign flush_done  = flush_done_reg;
  assign update_fire = update_valid && update_ready;

  // ---------------------------------------------------------------------------
  // Shared update datapath (next-value rule)
  // ---------------------------------------------------------------------------
  assign update_current = entry_reg[update_index];

  always_comb begin
    update_value_next = update_current;
    if (update_increment && !update_decrement) begin
      if (update_current != MAX_COUNT) begin
        update_value_next = (update_current == LOW_COUNT) ? JUMP_UP
                                                          : update_current + 1'b1;
      end
    end else if (update_decrement && !update_increment) begin
      if (update_current != '0) begin
        update_value_next = (update_current == HIGH_COUNT) ? JUMP_DOWN
                                                           : update_current - 1'b1;
      end
    end
  end

  // Updates and flush writes never coincide: updates are accepted only in IDLE
  // and flush writes happen only in FLUSH.
  assign entry_wdata = flush_write ? RESET_COUNT : update_value_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    assign entry_we[gi] =
        (flush_write && (flush_ptr_reg == INDEX_WIDTH'(gi))) ||
        (update_fire && (update_index == INDEX_WIDTH'(gi)));
  end

  // The entries use asynchronous reset, so a reset in the middle of a flush
  // still leaves every entry at RESET_VALUE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= RESET_COUNT;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) begin
          entry_reg[i] <= entry_wdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup port: reads the array before the same-edge write lands, so a
  // same-cycle lookup and update to one index returns the pre-update value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lookup_valid_reg <= 1'b0;
      lookup_count_reg <= RESET_COUNT;
    end else begin
      lookup_valid_reg <= lookup_enable;
      if (lookup_enable) begin
        lookup_count_reg <= entry_reg[lookup_index];
      end
    end
  end

  assign lookup_valid = lookup_valid_reg;
  assign lookup_count = lookup_count_reg;
  assign lookup_taken = (lookup_count_reg >= HIGH_COUNT);

endmodule
